config_frame_fsm: RTL and testbench

CONFIG_FRAME_FSM -- requirements
Module: config_frame_fsm

---
 rtl/config_frame_fsm.sv | 116 +++++++++++
 tb/tb_config_frame_fsm.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/config_frame_fsm.sv
// rtl/config_frame_fsm.sv - configuration frame sequencer: sync word, address word, then one data word per row
// Optional FrameCount output enabled by defining CFG_FRAME_COUNT_EN.
module config_frame_fsm #(
  parameter int NumberOfRows    = 16,
  parameter int RowSelectWidth  = 5,
  parameter int FrameBitsPerRow = 32,
  parameter int DesyncFlag      = 20
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [FrameBitsPerRow-1:0] WriteData,
  input  logic                       WriteStrobe,
  output logic [FrameBitsPerRow-1:0] FrameAddressRegister,
  output logic                       LongFrameStrobe,
  output logic [RowSelectWidth-1:0]  RowSelect,
`ifdef CFG_FRAME_COUNT_EN
  output logic [15:0]                FrameCount,
`endif
  output logic                       Active
);

  localparam logic [FrameBitsPerRow-1:0] SyncWord = FrameBitsPerRow'(32'hFAB0_FAB1);
  localparam logic [RowSelectWidth-1:0]  RowLast  = RowSelectWidth'(NumberOfRows - 1);
  localparam logic [RowSelectWidth-1:0]  RowNone  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_next_state;
  logic [FrameBitsPerRow-1:0]   r_frame_addr;
  logic [FrameBitsPerRow-1:0]   w_next_frame_addr;
  logic [RowSelectWidth-1:0]    r_row_select;
  logic [RowSelectWidth-1:0]    w_next_row_select;
  logic                         r_long_frame;
  logic                         w_next_long_frame;
`ifdef CFG_FRAME_COUNT_EN
  logic [15:0]                  r_frame_count;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state      <= IDLE;
      r_frame_addr <= '0;
      r_row_select <= RowNone;
      r_long_frame <= 1'b0;
`ifdef CFG_FRAME_COUNT_EN
      r_frame_count <= 16'd0;
`endif
    end else begin
      r_state      <= w_next_state;
      r_frame_addr <= w_next_frame_addr;
      r_row_select <= w_next_row_select;
      r_long_frame <= w_next_long_frame;
`ifdef CFG_FRAME_COUNT_EN
      if (w_next_long_frame) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
`endif
    end
  end

  // The completion pulse is the only register that does not hold across idle cycles.
  always_comb begin
    w_next_state      = r_state;
    w_next_frame_addr = r_frame_addr;
    w_next_row_select = r_row_select;
    w_next_long_frame = 1'b0;
    if (WriteStrobe) begin
      unique case (r_state)
        IDLE: begin
          if (WriteData == SyncWord) begin
            w_next_state = ADDR;
          end
        end
        ADDR: begin
          w_next_frame_addr = WriteData;
          if (WriteData[DesyncFlag]) begin
            w_next_state      = IDLE;
            w_next_row_select = RowNone;
          end else begin
            w_next_state      = DATA;
            w_next_row_select = RowLast;
          end
        end
        DATA: begin
          if (r_row_select == '0) begin
            w_next_state      = ADDR;
            w_next_row_select = RowNone;
            w_next_long_frame = 1'b1;
          end else begin
            w_next_row_select = r_row_select - 1'b1;
          end
        end
        default: begin
          w_next_state      = IDLE;
          w_next_row_select = RowNone;
        end
      endcase
    end
  end

  always_comb begin
    FrameAddressRegister = r_frame_addr;
    LongFrameStrobe      = r_long_frame;
    RowSelect            = r_row_select;
    Active               = (r_state != IDLE);
`ifdef CFG_FRAME_COUNT_EN
    FrameCount           = r_frame_count;
`endif
  end

endmodule

// File: tb/tb_config_frame_fsm.sv
// tb/tb_config_frame_fsm.sv - randomized bench for config_frame_fsm against a frame-level reference model
// FrameCount checks are compiled only when CFG_FRAME_COUNT_EN is defined.
module tb_config_frame_fsm;

  localparam int          N    = 16;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] WriteData = '0;
  logic        WriteStrobe = 1'b0;
  logic [31:0] FrameAddressRegister;
  logic        LongFrameStrobe;
  logic [4:0]  RowSelect;
  logic        Active;
`ifdef CFG_FRAME_COUNT_EN
  logic [15:0] FrameCount;
`endif

  config_frame_fsm dut (
    .CLK                  (CLK),
    .reset                (reset),
    .WriteData            (WriteData),
    .WriteStrobe          (WriteStrobe),
    .FrameAddressRegister (FrameAddressRegister),
    .LongFrameStrobe      (LongFrameStrobe),
    .RowSelect            (RowSelect),
`ifdef CFG_FRAME_COUNT_EN
    .FrameCount           (FrameCount),
`endif
    .Active               (Active)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: "synced" means a sync word has been seen, "in_frame" means
  // an address was accepted and m_words data words of this frame have arrived.
  bit          m_synced;
  bit          m_in_frame;
  int          m_words;
  logic [31:0] m_addr;
  bit          m_lfs;
  logic [15:0] m_count;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit stb, input logic [31:0] d);
    m_lfs = 0;
    if (rst) begin
      m_synced = 0; m_in_frame = 0; m_words = 0; m_addr = '0; m_count = '0;
    end else if (stb) begin
      if (!m_synced) begin
        if (d == SYNC) m_synced = 1;
      end else if (!m_in_frame) begin
        m_addr = d;
        if (d[20]) m_synced = 0;
        else begin
          m_in_frame = 1;
          m_words = 0;
        end
      end else begin
        m_words++;
        if (m_words == N) begin
          m_in_frame = 0;
          m_lfs = 1;
          m_count = m_count + 16'd1;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_row;
    exp_row = m_in_frame ? 32'(N - 1 - m_words) : 32'h1F;
    check_val("row_select", 32'(RowSelect), exp_row);
    check_val("frame_addr", FrameAddressRegister, m_addr);
    check_val("long_frame_strobe", 32'(LongFrameStrobe), 32'(m_lfs));
    check_val("active", 32'(Active), 32'(m_synced));
`ifdef CFG_FRAME_COUNT_EN
    check_val("frame_count", 32'(FrameCount), 32'(m_count));
`endif
  endtask

  // Drive one cycle, apply the model on the edge and compare 1 ns later.
  task automatic cycle(input bit rst, input bit stb, input logic [31:0] d);
    reset = rst; WriteStrobe = stb; WriteData = d;
    @(posedge CLK);
    model_step(rst, stb, d);
    #1;
    check_all();
    reset = 0; WriteStrobe = 0;
  endtask

  task automatic frame(input logic [31:0] addr, input int max_gap);
    cycle(0, 1, addr);
    for (int i = 0; i < N; i++) begin
      int gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) cycle(0, 0, 32'($urandom));
      cycle(0, 1, 32'($urandom) & ~32'h0010_0000);
    end
  endtask

  initial begin
    logic [31:0] d;
    #1;
    cycle(1, 0, '0);
    check_val("reset_row", 32'(RowSelect), 32'h1F);
    check_val("reset_active", 32'(Active), 32'd0);

    // Ignored word in IDLE.
    cycle(0, 1, 32'h1234_5678);
    check_val("idle_ignore_active", 32'(Active), 32'd0);

    // Full frame, then pulse visible one cycle only.
    cycle(0, 1, SYNC);
    cycle(0, 1, 32'h0000_0001);
    check_val("first_row", 32'(RowSelect), 32'd15);
    for (int i = 0; i < N; i++) cycle(0, 1, 32'(i * 3 + 7));
    check_val("frame_done_pulse", 32'(LongFrameStrobe), 32'd1);
    cycle(0, 0, '0);
    check_val("pulse_one_cycle", 32'(LongFrameStrobe), 32'd0);
    check_val("back_in_addr_active", 32'(Active), 32'd1);

    // Desync address word.
    cycle(0, 1, 32'h0010_0000);
    check_val("desync_addr", FrameAddressRegister, 32'h0010_0000);
    check_val("desync_active", 32'(Active), 32'd0);

    // Sync word as data, then reset mid-frame after 7 words.
    cycle(0, 1, SYNC);
    cycle(0, 1, 32'h0000_0042);
    cycle(0, 1, SYNC);
    check_val("sync_as_data", 32'(RowSelect), 32'd14);
    for (int i = 0; i < 6; i++) cycle(0, 1, 32'hA5A5_0000 + 32'(i));
    cycle(1, 1, '0);
    check_val("mid_reset_row", 32'(RowSelect), 32'h1F);
    check_val("mid_reset_lfs", 32'(LongFrameStrobe), 32'd0);

`ifdef CFG_FRAME_COUNT_EN
    cycle(0, 1, SYNC);
    for (int f = 0; f < 3; f++) frame(32'h0000_0100 + 32'(f), 4);
    check_val("three_frames", 32'(FrameCount), 32'd3);
    @(negedge CLK);
    dut.r_frame_count = 16'hFFFF;
    m_count = 16'hFFFF;
    frame(32'h0000_0200, 0);
    check_val("count_wrap", 32'(FrameCount), 32'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      int r = int'($urandom_range(99, 0));
      d = 32'($urandom);
      if ($urandom_range(7, 0) != 0) d[20] = 1'b0;
      if (r < 15) d = SYNC;
      cycle((r == 99), ($urandom_range(3, 0) != 0), d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
